water_level_emulator: RTL and testbench

Sequential tank model that drives the three water-level sensor lines (low, mid, high) consumed by the water-supply sensor checking and control logic. It integrates a tank volume from pump-fill and drain commands at a prescaled rate and produces thermometer-coded sensor outputs. A fault-injection path forces arbitrary sensor patterns so the conflict-detection path can be exercised on the board and in simulation.

---
 rtl/water_level_emulator_pkg.sv | 16 +
 rtl/water_level_emulator_tick_divider.sv | 41 ++++
 rtl/water_level_emulator.sv | 110 +++++++++++
 tb/tb_water_level_emulator.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/water_level_emulator_pkg.sv
// Shared water-supply definitions: default volume width, sensor thresholds and
// the {high, mid, low} sensor bit ordering used by the checker and pump control.
package water_level_emulator_pkg;

  localparam int LEVEL_WIDTH_DEF = 8;
  localparam int LOW_THRESH_DEF  = 32;
  localparam int MID_THRESH_DEF  = 128;
  localparam int HIGH_THRESH_DEF = 224;

  localparam int SENS_LOW  = 0;
  localparam int SENS_MID  = 1;
  localparam int SENS_HIGH = 2;

  typedef logic [2:0] sensor_vec_t;

endpackage

// File: rtl/water_level_emulator_tick_divider.sv
// Prescaler producing a one-cycle tick every TICK_DIV clocks; the tick is
// registered and coincides with the count sitting at TICK_DIV-1.
module tick_divider #(
  parameter int TICK_DIV = 1000
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic             tick_r;

  // Next prescaler count with wrap at the last value
  always_comb begin
    cnt_next_s = '0;
    if (cnt_r == LAST) begin
      cnt_next_s = '0;
    end else begin
      cnt_next_s = cnt_r + CNT_W'(1);
    end
  end

  // Count register; tick is raised for the cycle in which the count is LAST
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_next_s;
      tick_r <= (cnt_next_s == LAST);
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/water_level_emulator.sv
// Tank model: integrates volume from fill/drain at the prescaled rate and drives
// thermometer-coded level sensors, with a registered fault-injection override.
module water_level_emulator
  import water_level_emulator_pkg::*;
#(
  parameter int LEVEL_WIDTH = LEVEL_WIDTH_DEF,
  parameter int TICK_DIV    = 1000,
  parameter int FILL_RATE   = 2,
  parameter int DRAIN_RATE  = 1,
  parameter int LOW_THRESH  = LOW_THRESH_DEF,
  parameter int MID_THRESH  = MID_THRESH_DEF,
  parameter int HIGH_THRESH = HIGH_THRESH_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   fill_en,
  input  logic                   drain_en,
  input  logic                   fault_inject,
  input  logic [2:0]             fault_pattern,
  output logic                   low_level,
  output logic                   mid_level,
  output logic                   high_level,
  output logic [LEVEL_WIDTH-1:0] level,
  output logic                   empty,
  output logic                   overflow,
  output logic                   tick
);

  localparam int SUM_W = LEVEL_WIDTH + 2;
  localparam logic [SUM_W-1:0] MAX_S   = SUM_W'((2 ** LEVEL_WIDTH) - 1);
  localparam logic [SUM_W-1:0] FILL_S  = SUM_W'(FILL_RATE);
  localparam logic [SUM_W-1:0] DRAIN_S = SUM_W'(DRAIN_RATE);

  logic                   tick_s;
  logic [SUM_W-1:0]       sum_s;
  logic [LEVEL_WIDTH-1:0] level_next_s;
  logic                   clip_hi_s;
  logic [LEVEL_WIDTH-1:0] level_r;
  logic                   empty_r;
  logic                   overflow_r;
  sensor_vec_t            sensors_r;

  function automatic sensor_vec_t thermo(input logic [LEVEL_WIDTH-1:0] lv);
    sensor_vec_t s;
    s            = 3'b000;
    s[SENS_LOW]  = (lv >= LEVEL_WIDTH'(LOW_THRESH));
    s[SENS_MID]  = (lv >= LEVEL_WIDTH'(MID_THRESH));
    s[SENS_HIGH] = (lv >= LEVEL_WIDTH'(HIGH_THRESH));
    return s;
  endfunction

  tick_divider #(.TICK_DIV(TICK_DIV)) u_tick_divider (
    .clock (clock),
    .reset (reset),
    .tick  (tick_s)
  );

  // Net fill/drain delta in two's complement with two guard bits, then saturate
  always_comb begin
    sum_s        = {2'b00, level_r};
    level_next_s = level_r;
    clip_hi_s    = 1'b0;
    if (fill_en) begin
      sum_s = sum_s + FILL_S;
    end else begin
      sum_s = sum_s;
    end
    if (drain_en) begin
      sum_s = sum_s - DRAIN_S;
    end else begin
      sum_s = sum_s;
    end
    if (sum_s[SUM_W-1]) begin
      level_next_s = '0;
    end else if (sum_s > MAX_S) begin
      level_next_s = '1;
      clip_hi_s    = 1'b1;
    end else begin
      level_next_s = sum_s[LEVEL_WIDTH-1:0];
    end
  end

  // Volume, sticky overflow, and sensor/empty flags derived from the stored level
  always_ff @(posedge clock) begin
    if (reset) begin
      level_r    <= '0;
      overflow_r <= 1'b0;
      empty_r    <= 1'b1;
      sensors_r  <= 3'b000;
    end else begin
      if (tick_s) begin
        level_r <= level_next_s;
        if (clip_hi_s) begin
          overflow_r <= 1'b1;
        end
      end
      empty_r   <= (level_r == '0);
      sensors_r <= fault_inject ? fault_pattern : thermo(level_r);
    end
  end

  assign level      = level_r;
  assign empty      = empty_r;
  assign overflow   = overflow_r;
  assign tick       = tick_s;
  assign low_level  = sensors_r[SENS_LOW];
  assign mid_level  = sensors_r[SENS_MID];
  assign high_level = sensors_r[SENS_HIGH];

endmodule

// File: tb/tb_water_level_emulator.sv
// Directed bench for water_level_emulator at TICK_DIV=4 with hand-computed
// expectations for fill, drain, saturation, net rates, fault override and reset.
module tb_water_level_emulator;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       fill_en = 1'b0;
  logic       drain_en = 1'b0;
  logic       fault_inject = 1'b0;
  logic [2:0] fault_pattern = 3'b000;
  logic       low_level, mid_level, high_level;
  logic [7:0] level;
  logic       empty, overflow, tick;

  int n_checks = 0;
  int n_fail   = 0;

  water_level_emulator #(.TICK_DIV(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .fill_en       (fill_en),
    .drain_en      (drain_en),
    .fault_inject  (fault_inject),
    .fault_pattern (fault_pattern),
    .low_level     (low_level),
    .mid_level     (mid_level),
    .high_level    (high_level),
    .level         (level),
    .empty         (empty),
    .overflow      (overflow),
    .tick          (tick)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  // n ticks of update; starts and ends aligned just after an update edge
  task automatic run_ticks(input logic f, input logic d, input int n);
    fill_en  = f;
    drain_en = d;
    step(4 * n);
    fill_en  = 1'b0;
    drain_en = 1'b0;
  endtask

  function automatic logic [2:0] sens();
    return {high_level, mid_level, low_level};
  endfunction

  initial begin
    // Reset state and first tick timing
    step(1);
    do_reset();
    check_eq("rst_level", level, 0);
    check_eq("rst_empty", empty, 1);
    check_eq("rst_overflow", overflow, 0);
    check_eq("rst_sensors", sens(), 3'b000);
    check_eq("rst_tick", tick, 0);
    step(2);
    check_eq("tick_early", tick, 0);
    step(1);
    check_eq("tick_first", tick, 1);
    step(1);
    check_eq("tick_pulse_end", tick, 0);

    // Fill 16 ticks -> 32; sensors follow one cycle later
    run_ticks(1'b1, 1'b0, 16);
    check_eq("fill_level32", level, 32);
    check_eq("fill_low_lag", low_level, 0);
    step(1);
    check_eq("fill_sensors32", sens(), 3'b001);
    check_eq("fill_empty", empty, 0);
    step(3);

    // Drain from empty clips at 0 with no flag
    do_reset();
    run_ticks(1'b0, 1'b1, 5);
    check_eq("drain_level0", level, 0);
    step(1);
    check_eq("drain_empty", empty, 1);
    check_eq("drain_no_ovf", overflow, 0);
    step(3);

    // Fill to the top, clip, then drain to 200
    do_reset();
    run_ticks(1'b1, 1'b0, 127);
    check_eq("top_level254", level, 254);
    check_eq("top_no_ovf", overflow, 0);
    run_ticks(1'b1, 1'b0, 1);
    check_eq("top_level255", level, 255);
    check_eq("top_ovf", overflow, 1);
    run_ticks(1'b1, 1'b0, 1);
    check_eq("top_hold255", level, 255);
    step(1);
    check_eq("top_sensors", sens(), 3'b111);
    step(3);
    run_ticks(1'b0, 1'b1, 55);
    check_eq("drain_level200", level, 200);
    step(1);
    check_eq("drain_ovf_sticky", overflow, 1);
    check_eq("drain_sensors200", sens(), 3'b011);
    step(3);

    // Simultaneous fill and drain: net +1 per tick
    do_reset();
    run_ticks(1'b1, 1'b0, 50);
    check_eq("net_level100", level, 100);
    run_ticks(1'b1, 1'b1, 10);
    check_eq("net_level110", level, 110);
    step(1);
    check_eq("net_sensors110", sens(), 3'b001);
    step(3);

    // Fault override with one-cycle latency in and out
    fault_inject  = 1'b1;
    fault_pattern = 3'b100;
    check_eq("fault_lag_in", sens(), 3'b001);
    step(1);
    check_eq("fault_100", sens(), 3'b100);
    check_eq("fault_level", level, 110);
    fault_pattern = 3'b010;
    step(1);
    check_eq("fault_010", sens(), 3'b010);
    fault_inject = 1'b0;
    check_eq("fault_lag_out", sens(), 3'b010);
    step(1);
    check_eq("fault_exit", sens(), 3'b001);
    check_eq("fault_ovf", overflow, 0);
    step(1);

    // Reset one cycle before a tick while filling at 150
    do_reset();
    run_ticks(1'b1, 1'b0, 75);
    check_eq("pre_level150", level, 150);
    fill_en = 1'b1;
    step(2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check_eq("cancel_level", level, 0);
    check_eq("cancel_tick", tick, 0);
    step(1);
    check_eq("cancel_no_update", level, 0);
    step(1);
    check_eq("post_tick_early", tick, 0);
    step(1);
    check_eq("post_tick", tick, 1);
    step(1);
    check_eq("post_level2", level, 2);
    check_eq("post_tick_end", tick, 0);
    fill_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
